// File: rtl/sh_int_accept_pkg.sv
// rtl/sh_int_accept_pkg.sv - shared types and constants for the interrupt acceptance sequencer
package sh_int_accept_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PUSH_SR = 3'd1,
        ST_PUSH_PC = 3'd2,
        ST_VEC_RD  = 3'd3,
        ST_LOAD    = 3'd4
    } int_acc_state_t;

    localparam logic [7:0] NMI_VEC = 8'd11;
    localparam logic [7:0] AE_VEC  = 8'd9;

    typedef struct packed {
        logic [3:0] lvl;
        logic [7:0] vec;
    } int_req_t;

    typedef struct packed {
        logic       ack;
        logic [3:0] lvl;
    } int_ack_t;

    function automatic int_req_t int_req_unpack(input logic [11:0] flat);
        return int_req_t'(flat);
    endfunction

    function automatic logic [11:0] int_req_pack(input int_req_t r);
        return {r.lvl, r.vec};
    endfunction

    function automatic int_ack_t int_ack_unpack(input logic [4:0] flat);
        return int_ack_t'(flat);
    endfunction

    function automatic logic [4:0] int_ack_pack(input int_ack_t a);
        return {a.ack, a.lvl};
    endfunction

endpackage

// File: rtl/sh_int_accept_if.sv
// rtl/sh_int_accept_if.sv - interrupt controller handshake and bus signals of the acceptance sequencer
interface sh_int_accept_if;
    logic        REQ;
    logic [3:0]  REQ_LVL;
    logic [7:0]  REQ_VEC;
    logic        ACK;
    logic [3:0]  ACK_LVL;
    logic [31:0] BUS_A;
    logic [31:0] BUS_DO;
    logic [31:0] BUS_DI;
    logic        BUS_WE;
    logic        BUS_REQ;
    logic        BUS_BUSY;

    modport slave (
        input  REQ, REQ_LVL, REQ_VEC, BUS_BUSY, BUS_DI,
        output ACK, ACK_LVL, BUS_A, BUS_DO, BUS_WE, BUS_REQ
    );

    modport master (
        output REQ, REQ_LVL, REQ_VEC, BUS_BUSY, BUS_DI,
        input  ACK, ACK_LVL, BUS_A, BUS_DO, BUS_WE, BUS_REQ
    );
endinterface

// File: rtl/sh_int_accept_addr.sv
// rtl/sh_int_accept_addr.sv - stack push and vector table address generator (all mod 2^32)
module sh_int_accept_addr (
    input  logic [31:0] sp,
    input  logic [31:0] vbr,
    input  logic [7:0]  vec,
    output logic [31:0] sp_m4,
    output logic [31:0] sp_m8,
    output logic [31:0] vec_addr
);
    assign sp_m4    = sp - 32'd4;
    assign sp_m8    = sp - 32'd8;
    assign vec_addr = vbr + {22'b0, vec, 2'b00};
endmodule

// File: rtl/sh_int_accept.sv
// rtl/sh_int_accept.sv - interrupt acceptance and exception entry sequencer
// Optional: SH_INTACC_SP_CHECK_EN turns a misaligned SP into an address-error entry.
module sh_int_accept
    import sh_int_accept_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CE_R,
    input  logic              CE_F,
    sh_int_accept_if.slave    ifc,
    input  logic              SLOT,
    input  logic [3:0]        SR_I,
    input  logic [31:0]       SR,
    input  logic [31:0]       PC,
    input  logic [31:0]       VBR,
    input  logic [31:0]       SP,
    output logic              BUSY,
    output logic              LOAD,
    output logic [31:0]       NEW_PC,
    output logic [31:0]       NEW_SP,
    output logic [3:0]        NEW_SR_I
);
    int_acc_state_t state_q, state_d;
    int_req_t       req;
    logic           accept, skip_d, is_nmi, bus_done;
    logic           ack_q, skip_q, nmi_q;
    logic [3:0]     lvl_q, new_sr_i_q;
    logic [7:0]     vec_q;
    logic [31:0]    sr_q, pc_q, sp_q, vbr_q, new_pc_q, new_sp_q;
    logic [31:0]    sp_m4, sp_m8, vec_addr;
    logic           unused_ce_f;

    // Only the rising enable sequences this block.
    assign unused_ce_f = CE_F;

    assign req      = int_req_unpack({ifc.REQ_LVL, ifc.REQ_VEC});
    assign is_nmi   = (req.vec == NMI_VEC);
    assign accept   = (state_q == ST_IDLE) && CE_R && ifc.REQ && SLOT && (is_nmi || (req.lvl > SR_I));
    assign bus_done = CE_R && !ifc.BUS_BUSY;

`ifdef SH_INTACC_SP_CHECK_EN
    assign skip_d = (SP[1:0] != 2'b00);
`else
    assign skip_d = 1'b0;
`endif

    sh_int_accept_addr u_addr (
        .sp       (sp_q),
        .vbr      (vbr_q),
        .vec      (vec_q),
        .sp_m4    (sp_m4),
        .sp_m8    (sp_m8),
        .vec_addr (vec_addr)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            ack_q      <= 1'b0;
            skip_q     <= 1'b0;
            nmi_q      <= 1'b0;
            lvl_q      <= 4'h0;
            vec_q      <= 8'h00;
            sr_q       <= 32'h0;
            pc_q       <= 32'h0;
            sp_q       <= 32'h0;
            vbr_q      <= 32'h0;
            new_pc_q   <= 32'h0;
            new_sp_q   <= 32'h0;
            new_sr_i_q <= 4'h0;
        end else if (CE_R) begin
            state_q <= state_d;
            ack_q   <= accept;
            if (accept) begin
                lvl_q  <= req.lvl;
                vec_q  <= skip_d ? AE_VEC : req.vec;
                nmi_q  <= is_nmi;
                skip_q <= skip_d;
                sr_q   <= SR;
                pc_q   <= PC;
                sp_q   <= SP;
                vbr_q  <= VBR;
            end
            // Results are registered on vector-read completion so they are valid throughout LOAD.
            if ((state_q == ST_VEC_RD) && !ifc.BUS_BUSY) begin
                new_pc_q   <= ifc.BUS_DI;
                new_sp_q   <= skip_q ? sp_q : sp_m8;
                new_sr_i_q <= nmi_q ? 4'hF : lvl_q;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ifc.BUS_REQ = 1'b0;
        ifc.BUS_WE  = 1'b0;
        ifc.BUS_A   = 32'h0;
        ifc.BUS_DO  = 32'h0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = skip_d ? ST_VEC_RD : ST_PUSH_SR;
            end
            ST_PUSH_SR: begin
                ifc.BUS_REQ = 1'b1;
                ifc.BUS_WE  = 1'b1;
                ifc.BUS_A   = sp_m4;
                ifc.BUS_DO  = sr_q;
                if (bus_done) state_d = ST_PUSH_PC;
            end
            ST_PUSH_PC: begin
                ifc.BUS_REQ = 1'b1;
                ifc.BUS_WE  = 1'b1;
                ifc.BUS_A   = sp_m8;
                ifc.BUS_DO  = pc_q;
                if (bus_done) state_d = ST_VEC_RD;
            end
            ST_VEC_RD: begin
                ifc.BUS_REQ = 1'b1;
                ifc.BUS_A   = vec_addr;
                if (bus_done) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (CE_R) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outside IDLE the controller compares against the taken level so the request is not re-raised.
    assign ifc.ACK_LVL = (state_q == ST_IDLE) ? SR_I : lvl_q;
    assign ifc.ACK     = ack_q;
    assign BUSY        = (state_q != ST_IDLE);
    assign LOAD        = (state_q == ST_LOAD);
    assign NEW_PC      = new_pc_q;
    assign NEW_SP      = new_sp_q;
    assign NEW_SR_I    = new_sr_i_q;
endmodule
